// File: rtl/embedding_seq_ctrl.sv
// Sequencer in front of embedding_lookup: turns a row-oriented load stream
// into per-dim table writes, turns a token stream into position-tagged
// lookups, serialises the two on the shared table, and buffers results in a
// 2-entry first-word-fall-through FIFO.
module embedding_seq_ctrl #(
    parameter int VOCAB_SIZE  = 16,
    parameter int MAX_SEQ_LEN = 8,
    parameter int EMBED_DIM   = 4,
    parameter int DATA_WIDTH  = 16,
    localparam int TW  = $clog2(VOCAB_SIZE),
    localparam int PW  = $clog2(MAX_SEQ_LEN),
    localparam int DIW = $clog2(EMBED_DIM),
    localparam int DW  = DATA_WIDTH,
    localparam int ED  = EMBED_DIM
) (
    input  logic              clk,
    input  logic              rst,
    // load stream
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_is_pos,
    input  logic [TW-1:0]     ld_row,
    input  logic [DW-1:0]     ld_data,
    // token stream
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic [TW-1:0]     tok_id,
    input  logic              tok_last,
    // result stream
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ED*DW-1:0]  out_emb,
    output logic [PW-1:0]     out_pos,
    output logic              out_last,
    // status
    output logic              seq_overflow,
    output logic              busy,
    // embedding_lookup interface
    output logic              lk_load_token_emb,
    output logic              lk_load_pos_emb,
    output logic [TW-1:0]     lk_load_token_idx,
    output logic [PW-1:0]     lk_load_pos_idx,
    output logic [DIW-1:0]    lk_load_dim_idx,
    output logic [DW-1:0]     lk_load_data,
    output logic              lk_valid_in,
    output logic [TW-1:0]     lk_token_id,
    output logic [PW-1:0]     lk_position,
    input  logic [ED*DW-1:0]  lk_emb_out,
    input  logic              lk_valid_out
);

    localparam int CW = $clog2(MAX_SEQ_LEN + 1);

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } state_t;

    state_t          state, state_nxt;
    logic [DIW-1:0]  dim_cnt, dim_cnt_nxt;
    logic [TW-1:0]   row_q;
    logic            is_pos_q;
    logic [CW-1:0]   pos_cnt;
    logic            inflight;
    logic            last_q;

    logic            ld_priority;
    logic            lookup_grant;
    logic            ld_fire;
    logic            pos_full;
    logic            dim_last;
    logic [TW-1:0]   row_sel;
    logic            is_pos_sel;

    logic [ED*DW-1:0] fifo_emb  [2];
    logic [PW-1:0]    fifo_pos  [2];
    logic             fifo_last [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       fifo_cnt;
    logic             push, pop;

    // State register and row bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dim_cnt  <= '0;
            row_q    <= '0;
            is_pos_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            dim_cnt <= dim_cnt_nxt;
            if (ld_fire && state == S_IDLE) begin
                row_q    <= ld_row;
                is_pos_q <= ld_is_pos;
            end
        end
    end

    // Arbitration, handshakes and next-state logic.
    always_comb begin
        state_nxt    = state;
        dim_cnt_nxt  = dim_cnt;
        pos_full     = (pos_cnt == CW'(MAX_SEQ_LEN));
        ld_priority  = ld_valid && (state == S_IDLE);
        // The issue cycle also blocks a grant, so a single inflight bit is
        // enough credit and tokens are accepted at most every other cycle.
        tok_ready    = (state == S_IDLE) && !lk_valid_in &&
                       ((fifo_cnt + {1'b0, inflight}) < 2'd2) && !ld_priority;
        lookup_grant = tok_valid && tok_ready;
        ld_ready     = (state == S_LOAD) ||
                       ((state == S_IDLE) && !inflight && !lookup_grant);
        ld_fire      = ld_valid && ld_ready;
        dim_last     = (dim_cnt == DIW'(ED - 1));
        row_sel      = (state == S_IDLE) ? ld_row : row_q;
        is_pos_sel   = (state == S_IDLE) ? ld_is_pos : is_pos_q;
        if (ld_fire) begin
            if (dim_last) begin
                dim_cnt_nxt = '0;
                state_nxt   = S_IDLE;
            end else begin
                dim_cnt_nxt = dim_cnt + DIW'(1);
                state_nxt   = S_LOAD;
            end
        end
    end

    // Registered table-write pulse for each accepted load word.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_load_token_emb <= 1'b0;
            lk_load_pos_emb   <= 1'b0;
            lk_load_token_idx <= '0;
            lk_load_pos_idx   <= '0;
            lk_load_dim_idx   <= '0;
            lk_load_data      <= '0;
        end else begin
            lk_load_token_emb <= ld_fire && !is_pos_sel;
            lk_load_pos_emb   <= ld_fire && is_pos_sel;
            if (ld_fire) begin
                lk_load_token_idx <= row_sel;
                lk_load_pos_idx   <= row_sel[PW-1:0];
                lk_load_dim_idx   <= dim_cnt;
                lk_load_data      <= ld_data;
            end
        end
    end

    // Lookup issue, position counter, overflow flag and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_valid_in  <= 1'b0;
            lk_token_id  <= '0;
            lk_position  <= '0;
            last_q       <= 1'b0;
            pos_cnt      <= '0;
            seq_overflow <= 1'b0;
            inflight     <= 1'b0;
        end else begin
            lk_valid_in <= lookup_grant && !pos_full;
            if (lookup_grant && !pos_full) begin
                lk_token_id <= tok_id;
                lk_position <= pos_cnt[PW-1:0];
                last_q      <= tok_last;
                inflight    <= 1'b1;
            end else if (lk_valid_out) begin
                inflight <= 1'b0;
            end
            if (lookup_grant) begin
                if (tok_last)
                    pos_cnt <= '0;
                else if (!pos_full)
                    pos_cnt <= pos_cnt + CW'(1);
                if (pos_full)
                    seq_overflow <= 1'b1;
            end
        end
    end

    // Result FIFO: captures lookup results with their position/last tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_emb[wr_ptr]  <= lk_emb_out;
                fifo_pos[wr_ptr]  <= lk_position;
                fifo_last[wr_ptr] <= last_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO head presentation and status.
    always_comb begin
        push      = lk_valid_out;
        out_valid = (fifo_cnt != 2'd0);
        pop       = out_valid && out_ready;
        out_emb   = out_valid ? fifo_emb[rd_ptr]  : '0;
        out_pos   = out_valid ? fifo_pos[rd_ptr]  : '0;
        out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;
        busy      = (state == S_LOAD) || inflight || lk_valid_in || out_valid;
    end

endmodule
